// File: rtl/dp_batch_sequencer_pkg.sv
// Shared definitions for the dot-product batch sequencer: drain-mode
// encodings, stage slot indices, FSM states and a mod-3 step helper.
package dp_batch_sequencer_pkg;

   localparam logic [1:0] M_CTXT = 2'b01;
   localparam logic [1:0] M_PTXT = 2'b10;

   localparam int unsigned ST_LOAD  = 0;
   localparam int unsigned ST_NTT   = 1;
   localparam int unsigned ST_DRAIN = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   // Advance a buffer index through 0,1,2 without a divider.
   function automatic logic [1:0] mod3_inc(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

endpackage

// File: rtl/dp_batch_sequencer_done_tracker.sv
// Sticky per-core done collector for one pipeline stage. Flags clear in the
// ISSUE cycle, set from done pulses while the stage is outstanding, and any
// pulse that is not accepted is reported as a protocol error.
module dp_done_tracker #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_arm,
   input  logic [WIDTH-1:0] i_done,
   output logic             o_all_done,
   output logic             o_err
);

   logic [WIDTH-1:0] r_flags;
   logic [WIDTH-1:0] w_accept;

   assign w_accept   = i_arm ? (i_done & ~r_flags) : '0;
   // Completion counts pulses arriving in this very cycle.
   assign o_all_done = &(r_flags | w_accept);
   assign o_err      = |(i_done & ~w_accept);

   // Sticky OR of accepted done pulses, cleared on stage issue.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_flags <= '0;
      else if (i_clr)
         r_flags <= '0;
      else
         r_flags <= r_flags | w_accept;
   end

endmodule

// File: rtl/dp_batch_sequencer.sv
// Three-stage batch sequencer: load -> NTT -> drain over triple ping-pong
// buffers, one epoch per ISSUE/WAIT round, N+2 epochs per job.
module dp_batch_sequencer
   import dp_batch_sequencer_pkg::*;
#(
   parameter int unsigned NUM_CORE    = 2,
   parameter int unsigned NUM_SPLIT   = 4,
   parameter int unsigned BATCH_WIDTH = 8,
   parameter int unsigned SPLIT_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic [1:0]             i_mode,
   input  logic [BATCH_WIDTH-1:0] i_num_batch,
   input  logic                   i_abort,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err,
   output logic                   o_axi_start,
   output logic [1:0]             o_axi_buf,
   input  logic                   i_axi_done,
   output logic                   o_ntt_start,
   output logic [1:0]             o_ntt_buf,
   input  logic [NUM_CORE-1:0]    i_ntt_done,
   output logic                   o_madd_start,
   output logic                   o_wruram_start,
   output logic [1:0]             o_drain_buf,
   output logic [SPLIT_WIDTH-1:0] o_idx_split,
   input  logic [NUM_CORE-1:0]    i_madd_done,
   input  logic                   i_wruram_done
);

   // Split index of epoch 0 is (0-2) mod NUM_SPLIT.
   localparam logic [SPLIT_WIDTH-1:0] SPLIT_INIT =
      SPLIT_WIDTH'((NUM_SPLIT - (2 % NUM_SPLIT)) % NUM_SPLIT);
   localparam logic [SPLIT_WIDTH-1:0] SPLIT_LAST = SPLIT_WIDTH'(NUM_SPLIT - 1);

   state_t                 r_state;
   logic [1:0]             r_mode;
   logic [BATCH_WIDTH-1:0] r_num;
   logic [BATCH_WIDTH:0]   r_epoch;
   logic [2:0]             r_vld;
   logic                   r_busy, r_done, r_err;
   logic                   r_axi_start, r_ntt_start, r_madd_start, r_wruram_start;
   logic [1:0]             r_axi_buf, r_ntt_buf, r_drain_buf;
   logic [SPLIT_WIDTH-1:0] r_split;

   logic                   w_wait, w_issue, w_ptxt;
   logic [BATCH_WIDTH-1:0] w_num;
   logic [BATCH_WIDTH:0]   w_issue_epoch;
   logic [2:0]             w_vld;
   logic                   w_load_all, w_ntt_all, w_madd_all, w_wr_all;
   logic                   w_load_err, w_ntt_err, w_madd_err, w_wr_err;
   logic                   w_any_err, w_epoch_done, w_more;

   assign w_wait  = (r_state == S_WAIT);
   assign w_issue = (r_state == S_ISSUE);
   assign w_ptxt  = (r_mode == M_PTXT);

   // Slot validity is evaluated for the epoch about to be issued.
   assign w_num         = (r_state == S_IDLE) ? i_num_batch : r_num;
   assign w_issue_epoch = (r_state == S_IDLE) ? '0 : r_epoch + 1'b1;
   assign w_vld[ST_LOAD]  = (w_issue_epoch < {1'b0, w_num});
   assign w_vld[ST_NTT]   = (w_issue_epoch != '0) && (w_issue_epoch <= {1'b0, w_num});
   assign w_vld[ST_DRAIN] = (w_issue_epoch >= (BATCH_WIDTH+1)'(2));

   assign w_more = (r_epoch < ({1'b0, r_num} + 1'b1));

   dp_done_tracker #(.WIDTH(1)) u_load (
      .clk(clk), .rst_n(rst_n), .i_clr(w_issue),
      .i_arm(w_wait & r_vld[ST_LOAD]), .i_done(i_axi_done),
      .o_all_done(w_load_all), .o_err(w_load_err));

   dp_done_tracker #(.WIDTH(NUM_CORE)) u_ntt (
      .clk(clk), .rst_n(rst_n), .i_clr(w_issue),
      .i_arm(w_wait & r_vld[ST_NTT]), .i_done(i_ntt_done),
      .o_all_done(w_ntt_all), .o_err(w_ntt_err));

   // Drain is tracked per mode so a done of the wrong drain kind is an error.
   dp_done_tracker #(.WIDTH(NUM_CORE)) u_madd (
      .clk(clk), .rst_n(rst_n), .i_clr(w_issue),
      .i_arm(w_wait & r_vld[ST_DRAIN] & w_ptxt), .i_done(i_madd_done),
      .o_all_done(w_madd_all), .o_err(w_madd_err));

   dp_done_tracker #(.WIDTH(1)) u_wruram (
      .clk(clk), .rst_n(rst_n), .i_clr(w_issue),
      .i_arm(w_wait & r_vld[ST_DRAIN] & ~w_ptxt), .i_done(i_wruram_done),
      .o_all_done(w_wr_all), .o_err(w_wr_err));

   assign w_any_err    = w_load_err | w_ntt_err | w_madd_err | w_wr_err;
   assign w_epoch_done = (~r_vld[ST_LOAD] | w_load_all) &
                         (~r_vld[ST_NTT]  | w_ntt_all) &
                         (~r_vld[ST_DRAIN] | (w_ptxt ? w_madd_all : w_wr_all));

   // Sequencer FSM with registered start pulses, buffer/split rotation and status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_mode         <= '0;
         r_num          <= '0;
         r_epoch        <= '0;
         r_vld          <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_axi_start    <= 1'b0;
         r_ntt_start    <= 1'b0;
         r_madd_start   <= 1'b0;
         r_wruram_start <= 1'b0;
         r_axi_buf      <= '0;
         r_ntt_buf      <= '0;
         r_drain_buf    <= '0;
         r_split        <= '0;
      end else begin
         r_axi_start    <= 1'b0;
         r_ntt_start    <= 1'b0;
         r_madd_start   <= 1'b0;
         r_wruram_start <= 1'b0;
         r_done         <= 1'b0;
         if (w_any_err)
            r_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_mode == M_CTXT || i_mode == M_PTXT) begin
                     r_mode      <= i_mode;
                     r_num       <= i_num_batch;
                     r_epoch     <= '0;
                     r_err       <= w_any_err;
                     r_busy      <= 1'b1;
                     r_axi_buf   <= 2'd0;
                     r_ntt_buf   <= 2'd2;
                     r_drain_buf <= 2'd1;
                     r_split     <= SPLIT_INIT;
                     if (i_num_batch == '0) begin
                        r_state <= S_FIN;
                     end else begin
                        r_state     <= S_ISSUE;
                        r_vld       <= w_vld;
                        r_axi_start <= w_vld[ST_LOAD];
                     end
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (i_abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_epoch_done) begin
                  r_epoch <= w_issue_epoch;
                  if (w_more) begin
                     r_state        <= S_ISSUE;
                     r_vld          <= w_vld;
                     r_axi_start    <= w_vld[ST_LOAD];
                     r_ntt_start    <= w_vld[ST_NTT];
                     r_madd_start   <= w_vld[ST_DRAIN] & w_ptxt;
                     r_wruram_start <= w_vld[ST_DRAIN] & ~w_ptxt;
                     r_axi_buf      <= mod3_inc(r_axi_buf);
                     r_ntt_buf      <= mod3_inc(r_ntt_buf);
                     r_drain_buf    <= mod3_inc(r_drain_buf);
                     r_split        <= (r_split == SPLIT_LAST) ? '0 : r_split + 1'b1;
                  end else begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_FIN: begin
               // Entry from WAIT already raised o_done; an empty job raises it here,
               // one cycle later, so both paths emit exactly one pulse.
               if (r_done) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_axi_start    = r_axi_start;
   assign o_axi_buf      = r_axi_buf;
   assign o_ntt_start    = r_ntt_start;
   assign o_ntt_buf      = r_ntt_buf;
   assign o_madd_start   = r_madd_start;
   assign o_wruram_start = r_wruram_start;
   assign o_drain_buf    = r_drain_buf;
   assign o_idx_split    = r_split;

endmodule

// File: tb/tb_dp_batch_sequencer.sv
// Directed self-checking bench for dp_batch_sequencer (NUM_CORE=2, NUM_SPLIT=4).
module tb_dp_batch_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_start;
   logic [1:0] i_mode;
   logic [7:0] i_num_batch;
   logic       i_abort;
   logic       o_busy, o_done, o_err;
   logic       o_axi_start, o_ntt_start, o_madd_start, o_wruram_start;
   logic [1:0] o_axi_buf, o_ntt_buf, o_drain_buf, o_idx_split;
   logic       i_axi_done, i_wruram_done;
   logic [1:0] i_ntt_done, i_madd_done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dp_batch_sequencer #(
      .NUM_CORE(2), .NUM_SPLIT(4), .BATCH_WIDTH(8), .SPLIT_WIDTH(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
      .i_num_batch(i_num_batch), .i_abort(i_abort), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err), .o_axi_start(o_axi_start),
      .o_axi_buf(o_axi_buf), .i_axi_done(i_axi_done), .o_ntt_start(o_ntt_start),
      .o_ntt_buf(o_ntt_buf), .i_ntt_done(i_ntt_done), .o_madd_start(o_madd_start),
      .o_wruram_start(o_wruram_start), .o_drain_buf(o_drain_buf),
      .o_idx_split(o_idx_split), .i_madd_done(i_madd_done),
      .i_wruram_done(i_wruram_done)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_dones();
      i_axi_done = 1'b0; i_ntt_done = 2'b00; i_madd_done = 2'b00; i_wruram_done = 1'b0;
   endtask

   // Drive i_start for one cycle; returns in the first ISSUE cycle.
   task automatic start_job(input logic [1:0] mode, input logic [7:0] n);
      i_start = 1'b1; i_mode = mode; i_num_batch = n;
      tick();
      i_start = 1'b0;
   endtask

   // From an ISSUE cycle: answer every valid slot of epoch e in the WAIT cycle.
   task automatic drive_epoch(input int e, input int n, input bit ptxt);
      tick();
      i_axi_done    = (e < n);
      i_ntt_done    = (e >= 1 && e <= n) ? 2'b11 : 2'b00;
      i_madd_done   = (e >= 2 && ptxt) ? 2'b11 : 2'b00;
      i_wruram_done = (e >= 2 && !ptxt);
      tick();
      clear_dones();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_tests++;
      if ({o_busy, o_done, o_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_status got %b expected 000", {o_busy, o_done, o_err});
      end
      n_tests++;
      if ({o_axi_start, o_ntt_start, o_madd_start, o_wruram_start} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_starts got %b expected 0000",
                            {o_axi_start, o_ntt_start, o_madd_start, o_wruram_start});
      end
      n_tests++;
      if ({o_axi_buf, o_ntt_buf, o_drain_buf, o_idx_split} !== 8'h00) begin
         n_fail++; $display("FAIL reset_bufs got %h expected 00",
                            {o_axi_buf, o_ntt_buf, o_drain_buf, o_idx_split});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_n1_ptxt();
      start_job(2'b10, 8'd1);
      n_tests++;
      if ({o_busy, o_axi_start, o_ntt_start, o_madd_start, o_axi_buf} !== 6'b110000) begin
         n_fail++; $display("FAIL n1_ep0 got %b expected 110000",
                            {o_busy, o_axi_start, o_ntt_start, o_madd_start, o_axi_buf});
      end
      drive_epoch(0, 1, 1'b1);
      n_tests++;
      if ({o_axi_start, o_ntt_start, o_madd_start, o_axi_buf, o_ntt_buf} !== 7'b0100100) begin
         n_fail++; $display("FAIL n1_ep1 got %b expected 0100100",
                            {o_axi_start, o_ntt_start, o_madd_start, o_axi_buf, o_ntt_buf});
      end
      drive_epoch(1, 1, 1'b1);
      n_tests++;
      if ({o_axi_start, o_ntt_start, o_madd_start, o_wruram_start, o_axi_buf, o_drain_buf, o_idx_split}
          !== 10'b0010_10_00_00) begin
         n_fail++; $display("FAIL n1_ep2 got %b expected 0010100000",
            {o_axi_start, o_ntt_start, o_madd_start, o_wruram_start, o_axi_buf, o_drain_buf, o_idx_split});
      end
      drive_epoch(2, 1, 1'b1);
      n_tests++;
      if ({o_done, o_busy, o_err} !== 3'b110) begin
         n_fail++; $display("FAIL n1_done got %b expected 110", {o_done, o_busy, o_err});
      end
      tick();
      n_tests++;
      if ({o_done, o_busy} !== 2'b00) begin
         n_fail++; $display("FAIL n1_idle got %b expected 00", {o_done, o_busy});
      end
   endtask

   task automatic test_n5_ctxt();
      logic [3:0] exp_st;
      logic [1:0] exp_sp;
      int         epochs = 0;
      start_job(2'b01, 8'd5);
      for (int e = 0; e < 7; e++) begin
         exp_st = {(e < 5), (e >= 1 && e <= 5), 1'b0, (e >= 2)};
         n_tests++;
         if ({o_axi_start, o_ntt_start, o_madd_start, o_wruram_start} !== exp_st) begin
            n_fail++; $display("FAIL n5_starts e=%0d got %b expected %b", e,
               {o_axi_start, o_ntt_start, o_madd_start, o_wruram_start}, exp_st);
         end
         n_tests++;
         if ({o_axi_buf, o_ntt_buf, o_drain_buf} !== {2'(e % 3), 2'((e + 2) % 3), 2'((e + 1) % 3)}) begin
            n_fail++; $display("FAIL n5_bufs e=%0d got %b expected %b", e,
               {o_axi_buf, o_ntt_buf, o_drain_buf}, {2'(e % 3), 2'((e + 2) % 3), 2'((e + 1) % 3)});
         end
         n_tests++;
         if (o_axi_buf === o_ntt_buf || o_axi_buf === o_drain_buf || o_ntt_buf === o_drain_buf) begin
            n_fail++; $display("FAIL n5_collision e=%0d got %b expected distinct", e,
               {o_axi_buf, o_ntt_buf, o_drain_buf});
         end
         if (e >= 2) begin
            exp_sp = 2'((e - 2) % 4);
            n_tests++;
            if (o_idx_split !== exp_sp) begin
               n_fail++; $display("FAIL n5_split e=%0d got %0d expected %0d", e, o_idx_split, exp_sp);
            end
         end
         if (o_axi_start || o_ntt_start || o_wruram_start) epochs++;
         drive_epoch(e, 5, 1'b0);
      end
      n_tests++;
      if ({o_done, o_madd_start, o_err} !== 3'b100 || epochs != 7) begin
         n_fail++; $display("FAIL n5_done got done/madd/err=%b epochs=%0d expected 100 epochs=7",
                            {o_done, o_madd_start, o_err}, epochs);
      end
      tick();
   endtask

   task automatic test_staggered();
      start_job(2'b10, 8'd2);
      drive_epoch(0, 2, 1'b1);
      n_tests++;
      if ({o_axi_start, o_ntt_start} !== 2'b11) begin
         n_fail++; $display("FAIL stag_ep1 got %b expected 11", {o_axi_start, o_ntt_start});
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         clear_dones();
         n_tests++;
         if (k < 10) begin
            if ({o_axi_start, o_ntt_start, o_madd_start} !== 3'b000) begin
               n_fail++; $display("FAIL stag_early k=%0d got %b expected 000", k,
                                  {o_axi_start, o_ntt_start, o_madd_start});
            end
         end else begin
            if ({o_axi_start, o_ntt_start, o_madd_start} !== 3'b011) begin
               n_fail++; $display("FAIL stag_issue k=%0d got %b expected 011", k,
                                  {o_axi_start, o_ntt_start, o_madd_start});
            end
         end
         if (k == 1) i_axi_done = 1'b1;
         if (k == 3) i_ntt_done = 2'b01;
         if (k == 9) i_ntt_done = 2'b10;
      end
      drive_epoch(2, 2, 1'b1);
      drive_epoch(3, 2, 1'b1);
      n_tests++;
      if ({o_done, o_err} !== 2'b10) begin
         n_fail++; $display("FAIL stag_done got %b expected 10", {o_done, o_err});
      end
      tick();
   endtask

   task automatic test_spurious();
      start_job(2'b10, 8'd1);
      tick();
      i_madd_done = 2'b01;
      tick();
      clear_dones();
      n_tests++;
      if ({o_err, o_axi_start, o_ntt_start} !== 3'b100) begin
         n_fail++; $display("FAIL spur_err got %b expected 100", {o_err, o_axi_start, o_ntt_start});
      end
      i_axi_done = 1'b1;
      tick();
      clear_dones();
      drive_epoch(1, 1, 1'b1);
      drive_epoch(2, 1, 1'b1);
      n_tests++;
      if ({o_done, o_err} !== 2'b11) begin
         n_fail++; $display("FAIL spur_done got %b expected 11", {o_done, o_err});
      end
      tick();
   endtask

   task automatic test_illegal_mode();
      start_job(2'b11, 8'd2);
      n_tests++;
      if ({o_err, o_busy, o_axi_start} !== 3'b100) begin
         n_fail++; $display("FAIL illegal_mode got %b expected 100", {o_err, o_busy, o_axi_start});
      end
   endtask

   task automatic test_n0();
      start_job(2'b01, 8'd0);
      n_tests++;
      if ({o_done, o_busy, o_err, o_axi_start} !== 4'b0100) begin
         n_fail++; $display("FAIL n0_t1 got %b expected 0100", {o_done, o_busy, o_err, o_axi_start});
      end
      tick();
      n_tests++;
      if ({o_done, o_axi_start, o_ntt_start, o_madd_start, o_wruram_start} !== 5'b10000) begin
         n_fail++; $display("FAIL n0_t2 got %b expected 10000",
                            {o_done, o_axi_start, o_ntt_start, o_madd_start, o_wruram_start});
      end
      tick();
      n_tests++;
      if ({o_done, o_busy} !== 2'b00) begin
         n_fail++; $display("FAIL n0_t3 got %b expected 00", {o_done, o_busy});
      end
   endtask

   task automatic test_abort_reset();
      logic seen;
      start_job(2'b10, 8'd3);
      drive_epoch(0, 3, 1'b1);
      drive_epoch(1, 3, 1'b1);
      tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      n_tests++;
      if ({o_busy, o_done} !== 2'b00) begin
         n_fail++; $display("FAIL abort_idle got %b expected 00", {o_busy, o_done});
      end
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         seen |= o_done | o_axi_start | o_ntt_start | o_madd_start | o_wruram_start;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL abort_quiet got %b expected 0", seen);
      end
      start_job(2'b10, 8'd3);
      tick();
      rst_n = 1'b0;
      tick();
      n_tests++;
      if ({o_busy, o_done, o_err, o_axi_start, o_ntt_start, o_madd_start, o_wruram_start,
           o_axi_buf, o_ntt_buf, o_drain_buf, o_idx_split} !== 15'd0) begin
         n_fail++; $display("FAIL reset_mid got %b expected 0",
            {o_busy, o_done, o_err, o_axi_start, o_ntt_start, o_madd_start, o_wruram_start,
             o_axi_buf, o_ntt_buf, o_drain_buf, o_idx_split});
      end
      rst_n = 1'b1;
      tick();
      start_job(2'b10, 8'd1);
      n_tests++;
      if ({o_axi_start, o_axi_buf, o_ntt_buf, o_drain_buf} !== 7'b1_00_10_01) begin
         n_fail++; $display("FAIL reentry got %b expected 1001001",
                            {o_axi_start, o_axi_buf, o_ntt_buf, o_drain_buf});
      end
      drive_epoch(0, 1, 1'b1);
      drive_epoch(1, 1, 1'b1);
      drive_epoch(2, 1, 1'b1);
      n_tests++;
      if (o_done !== 1'b1) begin
         n_fail++; $display("FAIL reentry_done got %b expected 1", o_done);
      end
      tick();
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_mode = 2'b00; i_num_batch = '0; i_abort = 1'b0;
      clear_dones();
      test_reset();
      test_n1_ptxt();
      test_n5_ctxt();
      test_staggered();
      test_spurious();
      test_illegal_mode();
      test_n0();
      test_abort_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
